// File: rtl/mfu_mac_pe_if.sv
// Handshake and payload bundle for the precision-scalable MAC PE.
interface mfu_mac_pe_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [1:0]       mode;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;
    logic             out_err;

    // Producer of beats / consumer of results
    modport master (
        output in_valid, a, b, mode, last, out_ready,
        input  in_ready, out_valid, acc_out, out_cnt, out_ovf, out_err
    );

    // The PE itself
    modport slave (
        input  in_valid, a, b, mode, last, out_ready,
        output in_ready, out_valid, acc_out, out_cnt, out_ovf, out_err
    );
endinterface

// File: rtl/mfu_mac_pe.sv
// Pipelined precision-scalable multiply-accumulate PE: one 8x8, two 4x4 or four
// 2x2 signed products per beat, accumulated per group and emitted on 'last'.
module mfu_mac_pe #(
    parameter int unsigned ACC_W = 32,
    parameter bit          SAT   = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        nrst,
    mfu_mac_pe_if.slave io
);
    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned SUM_W  = ACC_W + 1;

    localparam logic [1:0] MODE_8X8  = 2'b00;
    localparam logic [1:0] MODE_4X4  = 2'b01;
    localparam logic [1:0] MODE_2X2  = 2'b10;
    localparam logic [1:0] MODE_NOOP = 2'b11;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic stall;

    // S1 operand registers
    logic            s1_valid;
    logic [OP_W-1:0] s1_a;
    logic [OP_W-1:0] s1_b;
    logic [1:0]      s1_mode;
    logic            s1_last;

    // S2 product registers
    logic signed [PROD_W-1:0] prod_c;
    logic                     s2_valid;
    logic signed [PROD_W-1:0] s2_prod;
    logic [1:0]               s2_mode;
    logic                     s2_last;

    // S3 group state
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    grp_ovf;
    logic                    grp_err;
    logic                    grp_set;
    logic [1:0]              grp_mode;

    logic                     beat_err_c;
    logic                     beat_ovf_c;
    logic signed [PROD_W-1:0] prod_use_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  acc_nxt_c;
    logic [CNT_W-1:0]         cnt_nxt_c;

    // Result registers
    logic             res_valid;
    logic [ACC_W-1:0] res_acc;
    logic [CNT_W-1:0] res_cnt;
    logic             res_ovf;
    logic             res_err;

    // A held result freezes the whole pipeline
    assign stall       = res_valid && !io.out_ready;
    assign io.in_ready = !stall;

    assign io.out_valid = res_valid;
    assign io.acc_out   = res_acc;
    assign io.out_cnt   = res_cnt;
    assign io.out_ovf   = res_ovf;
    assign io.out_err   = res_err;

    // S1: capture the incoming beat
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_NOOP;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= io.in_valid;
            s1_a     <= io.a;
            s1_b     <= io.b;
            s1_mode  <= io.mode;
            s1_last  <= io.last;
        end
    end

    // Lane products summed per mode, all lanes signed
    always_comb begin
        prod_c = '0;
        case (s1_mode)
            MODE_8X8: prod_c = PROD_W'($signed(s1_a)) * PROD_W'($signed(s1_b));
            MODE_4X4: prod_c = PROD_W'($signed(s1_a[7:4])) * PROD_W'($signed(s1_b[7:4]))
                             + PROD_W'($signed(s1_a[3:0])) * PROD_W'($signed(s1_b[3:0]));
            MODE_2X2: begin
                for (int k = 0; k < 4; k++) begin
                    prod_c = prod_c + PROD_W'($signed(s1_a[2*k +: 2])) * PROD_W'($signed(s1_b[2*k +: 2]));
                end
            end
            default: prod_c = '0;
        endcase
    end

    // S2: register the product
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_mode  <= MODE_NOOP;
            s2_last  <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_prod  <= prod_c;
            s2_mode  <= s1_mode;
            s2_last  <= s1_last;
        end
    end

    // Mode check, saturating/wrapping add and saturating beat count
    always_comb begin
        beat_err_c = (s2_mode != MODE_NOOP) && grp_set && (s2_mode != grp_mode);
        prod_use_c = beat_err_c ? '0 : s2_prod;
        sum_c      = SUM_W'(acc) + SUM_W'(prod_use_c);
        beat_ovf_c = sum_c[ACC_W] != sum_c[ACC_W-1];
        acc_nxt_c  = sum_c[ACC_W-1:0];
        if (beat_ovf_c && SAT) begin
            acc_nxt_c = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        cnt_nxt_c = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    // S3: accumulate and close the group on 'last'
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc       <= '0;
            cnt       <= '0;
            grp_ovf   <= 1'b0;
            grp_err   <= 1'b0;
            grp_set   <= 1'b0;
            grp_mode  <= MODE_8X8;
            res_valid <= 1'b0;
            res_acc   <= '0;
            res_cnt   <= '0;
            res_ovf   <= 1'b0;
            res_err   <= 1'b0;
        end else if (!stall) begin
            res_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    res_acc  <= acc_nxt_c;
                    res_cnt  <= cnt_nxt_c;
                    res_ovf  <= grp_ovf | beat_ovf_c;
                    res_err  <= grp_err | beat_err_c;
                    acc      <= '0;
                    cnt      <= '0;
                    grp_ovf  <= 1'b0;
                    grp_err  <= 1'b0;
                    grp_set  <= 1'b0;
                    grp_mode <= MODE_8X8;
                end else begin
                    acc     <= acc_nxt_c;
                    cnt     <= cnt_nxt_c;
                    grp_ovf <= grp_ovf | beat_ovf_c;
                    grp_err <= grp_err | beat_err_c;
                    if (!grp_set && (s2_mode != MODE_NOOP)) begin
                        grp_set  <= 1'b1;
                        grp_mode <= s2_mode;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mfu_mac_pe.sv
// Directed bench for mfu_mac_pe: single-beat vector table plus multi-beat,
// overflow, mode-mismatch, backpressure and reset sequences.
module tb_mfu_mac_pe;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned N_ACC = 16;
    localparam int unsigned N_CNT = 2;

    logic       clk = 1'b0;
    logic       nrst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic       last;
    logic       out_ready;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mfu_mac_pe_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) m_if();
    mfu_mac_pe_if #(.ACC_W(N_ACC), .CNT_W(N_CNT)) s_if();
    mfu_mac_pe_if #(.ACC_W(N_ACC), .CNT_W(N_CNT)) w_if();

    // Identical stimulus to every instance
    assign m_if.in_valid = in_valid;  assign s_if.in_valid = in_valid;  assign w_if.in_valid = in_valid;
    assign m_if.a = a;                assign s_if.a = a;                assign w_if.a = a;
    assign m_if.b = b;                assign s_if.b = b;                assign w_if.b = b;
    assign m_if.mode = mode;          assign s_if.mode = mode;          assign w_if.mode = mode;
    assign m_if.last = last;          assign s_if.last = last;          assign w_if.last = last;
    assign m_if.out_ready = out_ready; assign s_if.out_ready = out_ready; assign w_if.out_ready = out_ready;

    mfu_mac_pe #(.ACC_W(ACC_W), .SAT(1'b1), .CNT_W(CNT_W)) dut (.clk(clk), .nrst(nrst), .io(m_if.slave));
    mfu_mac_pe #(.ACC_W(N_ACC), .SAT(1'b1), .CNT_W(N_CNT)) dut_sat (.clk(clk), .nrst(nrst), .io(s_if.slave));
    mfu_mac_pe #(.ACC_W(N_ACC), .SAT(1'b0), .CNT_W(N_CNT)) dut_wrap (.clk(clk), .nrst(nrst), .io(w_if.slave));

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        int         exp_acc;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] tm,
                        input logic tl, output int unsigned acc_cyc);
        int budget = 0;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_; mode = tm; last = tl;
        #1;
        while (!m_if.in_ready && budget < 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!m_if.in_ready) chk("send_timeout", 0, 1);
        acc_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic wait_out(output logic got, output int unsigned seen_cyc);
        got      = 1'b0;
        seen_cyc = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (m_if.out_valid) begin
                got      = 1'b1;
                seen_cyc = cyc;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        int unsigned t0;
        int unsigned t1;
        int          got_n;
        int          first_c;
        int          last_c;
        logic [7:0]  k;

        vt[0] = '{"mul_80x80",  8'h80, 8'h80, 2'b00, 16384};
        vt[1] = '{"mul_7fx80",  8'h7F, 8'h80, 2'b00, -16256};
        vt[2] = '{"mul_ffx01",  8'hFF, 8'h01, 2'b00, -1};
        vt[3] = '{"dot4_73x2f", 8'h73, 8'h2F, 2'b01, 11};
        vt[4] = '{"dot4_88x88", 8'h88, 8'h88, 2'b01, 128};
        vt[5] = '{"dot4_7fx7f", 8'h7F, 8'h7F, 2'b01, 50};
        vt[6] = '{"dot2_ffxff", 8'hFF, 8'hFF, 2'b10, 4};
        vt[7] = '{"dot2_aax55", 8'hAA, 8'h55, 2'b10, -8};
        vt[8] = '{"dot2_80x80", 8'h80, 8'h80, 2'b10, 4};
        vt[9] = '{"noop",       8'h5A, 8'hA5, 2'b11, 0};

        // Reset state
        nrst = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = '0; last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", m_if.out_valid, 0);
        chk("rst_acc_out", m_if.acc_out, 0);
        chk("rst_out_cnt", m_if.out_cnt, 0);
        chk("rst_ovf_err", {m_if.out_ovf, m_if.out_err}, 0);
        nrst = 1'b1;
        #1;
        chk("rst_in_ready", m_if.in_ready, 1);

        // Single-beat groups from the table
        for (int i = 0; i < 10; i++) begin
            send(vt[i].a, vt[i].b, vt[i].mode, 1'b1, t0);
            idle();
            wait_out(got, t1);
            chk({vt[i].name, "_valid"}, got, 1);
            chk({vt[i].name, "_latency"}, t1 - t0, 3);
            chk({vt[i].name, "_acc"}, longint'($signed(m_if.acc_out)), vt[i].exp_acc);
            chk({vt[i].name, "_cnt"}, m_if.out_cnt, 1);
            chk({vt[i].name, "_ovf"}, m_if.out_ovf, 0);
            chk({vt[i].name, "_err"}, m_if.out_err, 0);
        end

        // Overflow: three 0x80*0x80 beats on 16-bit accumulators
        send(8'h80, 8'h80, 2'b00, 1'b0, t0);
        send(8'h80, 8'h80, 2'b00, 1'b0, t0);
        send(8'h80, 8'h80, 2'b00, 1'b1, t0);
        idle();
        wait_out(got, t1);
        chk("ovf_valid", got, 1);
        chk("sat_acc", longint'($signed(s_if.acc_out)), 32767);
        chk("sat_ovf", s_if.out_ovf, 1);
        chk("sat_cnt", s_if.out_cnt, 3);
        chk("wrap_acc", longint'($signed(w_if.acc_out)), -16384);
        chk("wrap_ovf", w_if.out_ovf, 1);
        chk("wide_acc", longint'($signed(m_if.acc_out)), 49152);
        chk("wide_ovf", m_if.out_ovf, 0);
        chk("wide_cnt", m_if.out_cnt, 3);

        // Counter saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) send(8'h11, 8'h11, 2'b01, (i == 4), t0);
        idle();
        wait_out(got, t1);
        chk("cntsat_valid", got, 1);
        chk("cntsat_narrow_cnt", s_if.out_cnt, 3);
        chk("cntsat_wide_cnt", m_if.out_cnt, 5);
        chk("cntsat_acc", longint'($signed(s_if.acc_out)), 10);

        // Mode mismatch, then a clean group
        send(8'h02, 8'h03, 2'b00, 1'b0, t0);
        send(8'h11, 8'h11, 2'b01, 1'b1, t0);
        send(8'h11, 8'h11, 2'b01, 1'b1, t0);
        idle();
        wait_out(got, t1);
        chk("mis_valid", got, 1);
        chk("mis_acc", longint'($signed(m_if.acc_out)), 6);
        chk("mis_cnt", m_if.out_cnt, 2);
        chk("mis_err", m_if.out_err, 1);
        wait_out(got, t1);
        chk("clean_valid", got, 1);
        chk("clean_acc", longint'($signed(m_if.acc_out)), 2);
        chk("clean_cnt", m_if.out_cnt, 1);
        chk("clean_err", m_if.out_err, 0);

        // Group mode set by first non-NOOP beat
        send(8'h00, 8'h00, 2'b11, 1'b0, t0);
        send(8'h73, 8'h2F, 2'b01, 1'b0, t0);
        send(8'h80, 8'h80, 2'b00, 1'b1, t0);
        idle();
        wait_out(got, t1);
        chk("noopfirst_valid", got, 1);
        chk("noopfirst_acc", longint'($signed(m_if.acc_out)), 11);
        chk("noopfirst_cnt", m_if.out_cnt, 3);
        chk("noopfirst_err", m_if.out_err, 1);

        // Backpressure while streaming 1-beat groups 1..5
        k = 8'd1; got_n = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 60 && got_n < 5; c++) begin
            @(negedge clk);
            out_ready = (c >= 8);
            if (k <= 8'd5) begin
                in_valid = 1'b1; a = k; b = 8'h01; mode = 2'b00; last = 1'b1;
            end else begin
                in_valid = 1'b0; last = 1'b0;
            end
            #1;
            if (c == 3) begin
                chk("stall_out_valid", m_if.out_valid, 1);
                chk("stall_in_ready", m_if.in_ready, 0);
            end
            if (m_if.out_valid && out_ready) begin
                chk("stream_order", longint'($signed(m_if.acc_out)), got_n + 1);
                if (first_c < 0) first_c = c;
                last_c = c;
                got_n++;
            end
            if (in_valid && m_if.in_ready) k = k + 8'd1;
        end
        chk("stream_count", got_n, 5);
        chk("stream_back_to_back", last_c - first_c, 4);
        out_ready = 1'b1;
        idle();

        // Reset in the middle of a group
        send(8'h05, 8'h05, 2'b00, 1'b0, t0);
        send(8'h05, 8'h05, 2'b00, 1'b0, t0);
        idle();
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("midrst_out_valid", m_if.out_valid, 0);
        chk("midrst_acc_out", m_if.acc_out, 0);
        chk("midrst_out_cnt", m_if.out_cnt, 0);
        @(negedge clk);
        nrst = 1'b1;
        send(8'h01, 8'h01, 2'b00, 1'b1, t0);
        idle();
        wait_out(got, t1);
        chk("postrst_valid", got, 1);
        chk("postrst_latency", t1 - t0, 3);
        chk("postrst_acc", longint'($signed(m_if.acc_out)), 1);
        chk("postrst_cnt", m_if.out_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
